// File: rtl/img_lut_bank_csr_pkg.sv
// rtl/img_lut_bank_csr_pkg.sv - shared constants and types for the LUT bank CSR block
//
// Holds the register word offsets, CTRL/STATUS field positions, the read FSM
// state type, AXI response codes and the address decode helper.
package img_lut_bank_csr_pkg;

    // Register word offsets from BASE_ADDR
    localparam logic [1:0] LUT_BANK_CTRL_CR   = 2'd0;
    localparam logic [1:0] LUT_BANK_ADDR_CR   = 2'd1;
    localparam logic [1:0] LUT_BANK_DATA_CR   = 2'd2;
    localparam logic [1:0] LUT_BANK_STATUS_CR = 2'd3;
    localparam int         LUT_BANK_CSR_CNT   = 4;

    // CTRL field positions
    localparam int CTRL_WR_MASK_LSB  = 0;
    localparam int CTRL_RD_CH_LSB    = 16;
    localparam int CTRL_RD_CH_MSB    = 18;
    localparam int CTRL_AUTO_INC_BIT = 31;

    // STATUS field positions
    localparam int STATUS_RD_BUSY_BIT = 0;
    localparam int STATUS_WR_CNT_LSB  = 16;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Returns {hit, word_index}. A hit needs a word-aligned byte address that
    // falls inside the register window.
    function automatic logic [2:0] csr_decode(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return {(off[31:2] < 30'(LUT_BANK_CSR_CNT)) && (off[1:0] == 2'b00), off[3:2]};
    endfunction

endpackage

// File: rtl/axi4_lite_wr_join.sv
// rtl/axi4_lite_wr_join.sv - joins independent AXI4-Lite AW/W beats into one write request
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_aw*/o_awready        write address channel
//   i_w*/o_wready          write data channel
//   o_bvalid/o_bresp/i_bready  registered write response
//   o_req                  high for one cycle when both beats are held
//   o_req_addr/data/strb   the held beats, stable while o_req is high
//   i_req_resp             response code for the current request (sampled with o_req)
module axi4_lite_wr_join #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_W-1:0]     i_awaddr,
    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic                  i_wvalid,
    output logic                  o_wready,
    output logic                  o_bvalid,
    output logic [1:0]            o_bresp,
    input  logic                  i_bready,
    output logic                  o_req,
    output logic [ADDR_W-1:0]     o_req_addr,
    output logic [DATA_W-1:0]     o_req_data,
    output logic [DATA_W/8-1:0]   o_req_strb,
    input  logic [1:0]            i_req_resp
);

    logic                r_aw_held;
    logic                r_w_held;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;

    // Held flags stay set through the B phase so each ready stays low until
    // the response completes; that keeps exactly one write outstanding.
    assign o_awready  = !r_aw_held;
    assign o_wready   = !r_w_held;
    assign o_req      = r_aw_held && r_w_held && !r_bvalid;
    assign o_req_addr = r_awaddr;
    assign o_req_data = r_wdata;
    assign o_req_strb = r_wstrb;
    assign o_bvalid   = r_bvalid;
    assign o_bresp    = r_bresp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (i_awvalid && !r_aw_held) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= i_awaddr;
            end
            if (i_wvalid && !r_w_held) begin
                r_w_held <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end
            if (o_req) begin
                r_bvalid <= 1'b1;
                r_bresp  <= i_req_resp;
            end
            if (r_bvalid && i_bready) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/img_lut_bank_csr.sv
// rtl/img_lut_bank_csr.sv - AXI4-Lite CSR front-end for a bank of per-channel pixel LUTs
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   csr_aw*/w*/b*           AXI4-Lite write channels (32-bit)
//   csr_ar*/r*              AXI4-Lite read channels (32-bit)
//   lut_wr_o                per-channel write enable pulse (from CTRL.wr_mask)
//   lut_wr_addr_o/data_o    shared write index and data
//   lut_rd_o/lut_rd_addr_o  read request pulse and index
//   lut_rd_data_i           all channels' read data, channel 0 in the LSBs,
//                           valid RD_LAT cycles after lut_rd_o
module img_lut_bank_csr
    import img_lut_bank_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CH_CNT    = 3,
    parameter int          PX_W      = 8,
    parameter int          RD_LAT    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              csr_awaddr_i,
    input  logic                     csr_awvalid_i,
    output logic                     csr_awready_o,
    input  logic [31:0]              csr_wdata_i,
    input  logic [3:0]               csr_wstrb_i,
    input  logic                     csr_wvalid_i,
    output logic                     csr_wready_o,
    output logic                     csr_bvalid_o,
    output logic [1:0]               csr_bresp_o,
    input  logic                     csr_bready_i,
    input  logic [31:0]              csr_araddr_i,
    input  logic                     csr_arvalid_i,
    output logic                     csr_arready_o,
    output logic                     csr_rvalid_o,
    output logic [31:0]              csr_rdata_o,
    output logic [1:0]               csr_rresp_o,
    input  logic                     csr_rready_i,
    output logic [CH_CNT-1:0]        lut_wr_o,
    output logic [PX_W-1:0]          lut_wr_addr_o,
    output logic [PX_W-1:0]          lut_wr_data_o,
    output logic                     lut_rd_o,
    output logic [PX_W-1:0]          lut_rd_addr_o,
    input  logic [CH_CNT*PX_W-1:0]   lut_rd_data_i
);

    // ---------------------------------------------------------------- write path
    logic        w_req;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_data;
    logic [3:0]  w_req_strb;
    logic [2:0]  w_wr_dec;
    logic        w_wr_hit;
    logic [1:0]  w_wr_idx;
    logic [1:0]  w_req_resp;

    logic [CH_CNT-1:0] r_wr_mask;
    logic [2:0]        r_rd_ch;
    logic              r_auto_inc;
    logic [PX_W-1:0]   r_addr;
    logic [15:0]       r_wr_cnt;
    logic              r_inc_pend;
    logic [CH_CNT-1:0] r_lut_wr;
    logic [PX_W-1:0]   r_lut_wr_addr;
    logic [PX_W-1:0]   r_lut_wr_data;
    logic [PX_W-1:0]   w_addr_next;

    axi4_lite_wr_join #(
        .ADDR_W (32),
        .DATA_W (32)
    ) u_wr_join (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_awaddr   (csr_awaddr_i),
        .i_awvalid  (csr_awvalid_i),
        .o_awready  (csr_awready_o),
        .i_wdata    (csr_wdata_i),
        .i_wstrb    (csr_wstrb_i),
        .i_wvalid   (csr_wvalid_i),
        .o_wready   (csr_wready_o),
        .o_bvalid   (csr_bvalid_o),
        .o_bresp    (csr_bresp_o),
        .i_bready   (csr_bready_i),
        .o_req      (w_req),
        .o_req_addr (w_req_addr),
        .o_req_data (w_req_data),
        .o_req_strb (w_req_strb),
        .i_req_resp (w_req_resp)
    );

    assign w_wr_dec   = csr_decode(w_req_addr, BASE_ADDR);
    assign w_wr_hit   = w_wr_dec[2];
    assign w_wr_idx   = w_wr_dec[1:0];
    assign w_req_resp = w_wr_hit ? RESP_OKAY : RESP_SLVERR;

    // Byte-strobe merge for the ADDR register (index may span two bytes).
    always_comb begin
        w_addr_next = r_addr;
        for (int i = 0; i < PX_W; i++) begin
            if (w_req_strb[i / 8]) begin
                w_addr_next[i] = w_req_data[i];
            end
        end
    end

    // Data and strobe bits outside the decoded fields are ignored.
    logic w_unused;
    assign w_unused = ^{w_req_data, w_req_strb};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_mask     <= '0;
            r_rd_ch       <= '0;
            r_auto_inc    <= 1'b0;
            r_addr        <= '0;
            r_wr_cnt      <= '0;
            r_inc_pend    <= 1'b0;
            r_lut_wr      <= '0;
            r_lut_wr_addr <= '0;
            r_lut_wr_data <= '0;
        end else begin
            r_lut_wr   <= '0;
            r_inc_pend <= 1'b0;
            // Auto-increment lands one cycle after the LUT write pulse so the
            // pulse carries the pre-increment index.
            if (r_inc_pend) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_req && w_wr_hit) begin
                case (w_wr_idx)
                    LUT_BANK_CTRL_CR: begin
                        if (w_req_strb[0]) r_wr_mask  <= w_req_data[CTRL_WR_MASK_LSB +: CH_CNT];
                        if (w_req_strb[2]) r_rd_ch    <= w_req_data[CTRL_RD_CH_MSB:CTRL_RD_CH_LSB];
                        if (w_req_strb[3]) r_auto_inc <= w_req_data[CTRL_AUTO_INC_BIT];
                    end
                    LUT_BANK_ADDR_CR: begin
                        r_addr <= w_addr_next;
                    end
                    LUT_BANK_DATA_CR: begin
                        if (w_req_strb[0]) begin
                            r_lut_wr      <= r_wr_mask;
                            r_lut_wr_addr <= r_addr;
                            r_lut_wr_data <= w_req_data[PX_W-1:0];
                            r_wr_cnt      <= r_wr_cnt + 16'd1;
                            r_inc_pend    <= r_auto_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign lut_wr_o      = r_lut_wr;
    assign lut_wr_addr_o = r_lut_wr_addr;
    assign lut_wr_data_o = r_lut_wr_data;

    // ----------------------------------------------------------------- read path
    rd_state_e       r_rd_state;
    logic [2:0]      r_rd_cnt;
    logic [31:0]     r_rdata;
    logic [1:0]      r_rresp;
    logic            r_lut_rd;
    logic [PX_W-1:0] r_lut_rd_addr;
    logic [2:0]      w_ar_dec;
    logic            w_ar_hit;
    logic [1:0]      w_ar_idx;
    logic            w_rd_busy;
    logic [31:0]     w_reg_rdata;
    logic [31:0]     w_lut_slice;

    assign w_ar_dec  = csr_decode(csr_araddr_i, BASE_ADDR);
    assign w_ar_hit  = w_ar_dec[2];
    assign w_ar_idx  = w_ar_dec[1:0];
    assign w_rd_busy = (r_rd_state == R_WAIT);

    always_comb begin
        w_reg_rdata = '0;
        case (w_ar_idx)
            LUT_BANK_CTRL_CR: begin
                w_reg_rdata[CTRL_WR_MASK_LSB +: CH_CNT]            = r_wr_mask;
                w_reg_rdata[CTRL_RD_CH_MSB:CTRL_RD_CH_LSB]          = r_rd_ch;
                w_reg_rdata[CTRL_AUTO_INC_BIT]                      = r_auto_inc;
            end
            LUT_BANK_ADDR_CR: begin
                w_reg_rdata[PX_W-1:0] = r_addr;
            end
            LUT_BANK_STATUS_CR: begin
                w_reg_rdata[STATUS_WR_CNT_LSB +: 16] = r_wr_cnt;
                w_reg_rdata[STATUS_RD_BUSY_BIT]      = w_rd_busy;
            end
            default: ;
        endcase
    end

    // Channel select; rd_ch values with no channel behind them read as zero.
    always_comb begin
        w_lut_slice = '0;
        for (int c = 0; c < CH_CNT; c++) begin
            if (r_rd_ch == 3'(c)) begin
                w_lut_slice[PX_W-1:0] = lut_rd_data_i[c*PX_W +: PX_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_state    <= R_IDLE;
            r_rd_cnt      <= '0;
            r_rdata       <= '0;
            r_rresp       <= RESP_OKAY;
            r_lut_rd      <= 1'b0;
            r_lut_rd_addr <= '0;
        end else begin
            r_lut_rd <= 1'b0;
            case (r_rd_state)
                R_IDLE: begin
                    if (csr_arvalid_i) begin
                        if (!w_ar_hit) begin
                            r_rdata    <= '0;
                            r_rresp    <= RESP_SLVERR;
                            r_rd_state <= R_RESP;
                        end else if (w_ar_idx == LUT_BANK_DATA_CR) begin
                            // Index is captured here so a later auto-increment
                            // cannot move an in-flight readback.
                            r_lut_rd      <= 1'b1;
                            r_lut_rd_addr <= r_addr;
                            r_rd_cnt      <= '0;
                            r_rresp       <= RESP_OKAY;
                            r_rd_state    <= R_WAIT;
                        end else begin
                            r_rdata    <= w_reg_rdata;
                            r_rresp    <= RESP_OKAY;
                            r_rd_state <= R_RESP;
                        end
                    end
                end
                R_WAIT: begin
                    // First R_WAIT cycle is the lut_rd_o cycle; data is valid
                    // RD_LAT cycles later.
                    if (r_rd_cnt == 3'(RD_LAT)) begin
                        r_rdata    <= w_lut_slice;
                        r_rd_state <= R_RESP;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 3'd1;
                    end
                end
                R_RESP: begin
                    if (csr_rready_i) begin
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign csr_arready_o = (r_rd_state == R_IDLE);
    assign csr_rvalid_o  = (r_rd_state == R_RESP);
    assign csr_rdata_o   = r_rdata;
    assign csr_rresp_o   = r_rresp;
    assign lut_rd_o      = r_lut_rd;
    assign lut_rd_addr_o = r_lut_rd_addr;

endmodule

// File: tb/tb_img_lut_bank_csr.sv
// tb/tb_img_lut_bank_csr.sv - directed self-checking bench for img_lut_bank_csr
module tb_img_lut_bank_csr;
    import img_lut_bank_csr_pkg::*;

    localparam int CH_CNT = 3;
    localparam int PX_W   = 8;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic [CH_CNT-1:0]      lut_wr_o;
    logic [PX_W-1:0]        lut_wr_addr_o, lut_wr_data_o, lut_rd_addr_o;
    logic                   lut_rd_o;
    logic [CH_CNT*PX_W-1:0] lut_rd_data_i;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    img_lut_bank_csr #(
        .BASE_ADDR (32'h0000_0000),
        .CH_CNT    (CH_CNT),
        .PX_W      (PX_W),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .csr_awaddr_i  (awaddr),
        .csr_awvalid_i (awvalid),
        .csr_awready_o (awready),
        .csr_wdata_i   (wdata),
        .csr_wstrb_i   (wstrb),
        .csr_wvalid_i  (wvalid),
        .csr_wready_o  (wready),
        .csr_bvalid_o  (bvalid),
        .csr_bresp_o   (bresp),
        .csr_bready_i  (bready),
        .csr_araddr_i  (araddr),
        .csr_arvalid_i (arvalid),
        .csr_arready_o (arready),
        .csr_rvalid_o  (rvalid),
        .csr_rdata_o   (rdata),
        .csr_rresp_o   (rresp),
        .csr_rready_i  (rready),
        .lut_wr_o      (lut_wr_o),
        .lut_wr_addr_o (lut_wr_addr_o),
        .lut_wr_data_o (lut_wr_data_o),
        .lut_rd_o      (lut_rd_o),
        .lut_rd_addr_o (lut_rd_addr_o),
        .lut_rd_data_i (lut_rd_data_i)
    );

    // LUT RAM model: data appears exactly RD_LAT cycles after lut_rd_o,
    // a poison pattern at every other time.
    logic [RD_LAT-1:0] rv_pipe = '0;
    logic [PX_W-1:0]   ra_pipe [RD_LAT];

    function automatic logic [CH_CNT*PX_W-1:0] lut_model(input logic [7:0] idx);
        return {idx ^ 8'h1A, idx ^ 8'h7C, idx};
    endfunction

    always @(posedge clk) begin
        rv_pipe[0] <= lut_rd_o;
        ra_pipe[0] <= lut_rd_addr_o;
        for (int s = 1; s < RD_LAT; s++) begin
            rv_pipe[s] <= rv_pipe[s-1];
            ra_pipe[s] <= ra_pipe[s-1];
        end
    end

    assign lut_rd_data_i = rv_pipe[RD_LAT-1] ? lut_model(ra_pipe[RD_LAT-1]) : 24'hC3C3C3;

    // Pulse monitors, sampled on the falling edge.
    logic [18:0] wr_q [$];
    logic [7:0]  rd_q [$];
    always @(negedge clk) begin
        if (!rst_i) begin
            if (|lut_wr_o) wr_q.push_back({lut_wr_o, lut_wr_addr_o, lut_wr_data_o});
            if (lut_rd_o)  rd_q.push_back(lut_rd_addr_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pulse(input string tag, input int i, input logic [2:0] m,
                             input logic [7:0] a, input logic [7:0] d);
        chk(tag, (wr_q.size() > i) ? 32'(wr_q[i]) : 32'hFFFF_FFFF, 32'({m, a, d}));
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        logic aw_done, w_done, hs_aw, hs_w;
        int   k;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; k = 0;
        while (!(aw_done && w_done) && k < 50) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (hs_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            k++;
        end
        k = 0;
        while (!bvalid && k < 50) begin tick(); k++; end
        if (!bvalid) chk("wr_b_timeout", 32'(bvalid), 32'd1);
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] r, output int lat, output logic busy);
        int k;
        busy = 1'b0;
        araddr = a; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin tick(); k++; end
        tick();
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 60) begin
            if (dut.w_rd_busy) busy = 1'b1;
            tick();
            lat++;
        end
        if (!rvalid) chk("rd_r_timeout", 32'(rvalid), 32'd1);
        d = rdata; r = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        busy;

    initial begin
        rst_i = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;

        // Reset state
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_lut_wr", 32'(lut_wr_o), 32'd0);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_awready", 32'(awready), 32'd1);

        axi_read(32'h0, d, r, lat, busy);
        chk("rst_ctrl", d, 32'h0); chk("rst_ctrl_resp", 32'(r), 32'(RESP_OKAY)); chk("reg_rd_lat", 32'(lat), 32'd1);
        axi_read(32'h4, d, r, lat, busy);
        chk("rst_addr", d, 32'h0); chk("rst_addr_resp", 32'(r), 32'(RESP_OKAY));
        axi_read(32'h8, d, r, lat, busy);
        chk("rst_data", d, 32'h0); chk("rst_data_resp", 32'(r), 32'(RESP_OKAY));
        axi_read(32'hC, d, r, lat, busy);
        chk("rst_status", d, 32'h0); chk("rst_status_resp", 32'(r), 32'(RESP_OKAY));
        axi_read(32'h10, d, r, lat, busy);
        chk("unmapped_rd_data", d, 32'h0); chk("unmapped_rd_resp", 32'(r), 32'(RESP_SLVERR));
        axi_read(32'h6, d, r, lat, busy);
        chk("misaligned_rd_resp", 32'(r), 32'(RESP_SLVERR));

        wr_q.delete();
        axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, r);
        chk("unmapped_wr_resp", 32'(r), 32'(RESP_SLVERR));
        chk("unmapped_wr_no_pulse", 32'(wr_q.size()), 32'd0);

        // Broadcast burst with auto-increment and index wrap
        axi_write(32'h0, 32'h8000_0007, 4'hF, r);
        chk("ctrl_wr_resp", 32'(r), 32'(RESP_OKAY));
        axi_write(32'h4, 32'h0000_00FE, 4'hF, r);
        wr_q.delete();
        axi_write(32'h8, 32'h11, 4'hF, r);
        axi_write(32'h8, 32'h22, 4'hF, r);
        axi_write(32'h8, 32'h33, 4'hF, r);
        chk("burst_npulse", 32'(wr_q.size()), 32'd3);
        chk_pulse("burst_p0", 0, 3'b111, 8'hFE, 8'h11);
        chk_pulse("burst_p1", 1, 3'b111, 8'hFF, 8'h22);
        chk_pulse("burst_p2", 2, 3'b111, 8'h00, 8'h33);
        axi_read(32'h4, d, r, lat, busy);
        chk("burst_addr", d, 32'h01);
        axi_read(32'hC, d, r, lat, busy);
        chk("burst_status", d, 32'h0003_0000);
        axi_read(32'h0, d, r, lat, busy);
        chk("ctrl_readback", d, 32'h8000_0007);

        // Masked single write without auto-increment
        axi_write(32'h0, 32'h0000_0002, 4'hF, r);
        axi_write(32'h4, 32'h0000_0040, 4'hF, r);
        wr_q.delete();
        axi_write(32'h8, 32'hA5, 4'hF, r);
        chk("mask_npulse", 32'(wr_q.size()), 32'd1);
        chk_pulse("mask_p0", 0, 3'b010, 8'h40, 8'hA5);
        axi_read(32'h4, d, r, lat, busy);
        chk("mask_addr_held", d, 32'h40);

        // DATA write without byte 0 is a no-op
        wr_q.delete();
        axi_write(32'h8, 32'hFFFF_FF5C, 4'b1110, r);
        chk("nostrb_resp", 32'(r), 32'(RESP_OKAY));
        chk("nostrb_npulse", 32'(wr_q.size()), 32'd0);
        axi_read(32'hC, d, r, lat, busy);
        chk("nostrb_status", d, 32'h0004_0000);

        // CTRL byte strobes: only rd_ch (byte 2) changes
        axi_write(32'h0, 32'h8002_00FF, 4'b0100, r);
        axi_read(32'h0, d, r, lat, busy);
        chk("ctrl_strb", d, 32'h0002_0002);

        // LUT readback of channel 2
        rd_q.delete();
        axi_read(32'h8, d, r, lat, busy);
        chk("lut_rd_data", d, 32'h5A);
        chk("lut_rd_resp", 32'(r), 32'(RESP_OKAY));
        chk("lut_rd_lat", 32'(lat), 32'(RD_LAT + 2));
        chk("lut_rd_busy", 32'(busy), 32'd1);
        chk("lut_rd_npulse", 32'(rd_q.size()), 32'd1);
        chk("lut_rd_idx", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hFFFF_FFFF, 32'h40);
        axi_read(32'h4, d, r, lat, busy);
        chk("lut_rd_addr_kept", d, 32'h40);

        // Channel beyond CH_CNT reads zero
        axi_write(32'h0, 32'h0005_0000, 4'b0100, r);
        axi_read(32'h8, d, r, lat, busy);
        chk("bad_ch_data", d, 32'h0);
        chk("bad_ch_resp", 32'(r), 32'(RESP_OKAY));

        // W three cycles ahead of AW, B back-pressured five cycles
        axi_write(32'h0, 32'h0000_0001, 4'hF, r);
        wr_q.delete();
        awaddr = 32'h8; wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        chk("early_w_ready", 32'(wready), 32'd1);
        tick();
        wvalid = 1'b0;
        chk("early_w_held", 32'(wready), 32'd0);
        tick(); tick();
        chk("early_w_no_b", 32'(bvalid), 32'd0);
        awvalid = 1'b1;
        chk("late_aw_ready", 32'(awready), 32'd1);
        tick();
        awaddr = 32'h4;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", 32'(bvalid), 32'd1);
            chk("bp_aw_blocked", 32'(awready), 32'd0);
            tick();
        end
        awvalid = 1'b0;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bp_b_done", 32'(bvalid), 32'd0);
        chk("bp_aw_reready", 32'(awready), 32'd1);
        chk("bp_npulse", 32'(wr_q.size()), 32'd1);
        chk_pulse("bp_p0", 0, 3'b001, 8'h40, 8'h77);
        axi_read(32'h4, d, r, lat, busy);
        chk("bp_addr", d, 32'h40);
        axi_read(32'hC, d, r, lat, busy);
        chk("bp_status", d, 32'h0005_0000);

        // Reset while a DATA readback is waiting
        araddr = 32'h8; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("pre_rst_busy", 32'(dut.w_rd_busy), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_wait_rvalid", 32'(rvalid), 32'd0);
        chk("rst_wait_fsm", 32'(dut.r_rd_state), 32'(R_IDLE));
        repeat (RD_LAT + 3) tick();
        chk("rst_wait_no_resp", 32'(rvalid), 32'd0);
        axi_read(32'h0, d, r, lat, busy);
        chk("rst2_ctrl", d, 32'h0);
        axi_read(32'h4, d, r, lat, busy);
        chk("rst2_addr", d, 32'h0);
        axi_read(32'hC, d, r, lat, busy);
        chk("rst2_status", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
